apb_mem_slave: RTL and testbench

- APB completer/responder: a small register-file memory that answers the transfers an APB requester drives on addr/wr_data/wr/sel/enable.
- Returns ready and out_data, with a configurable number of wait states.
- Serves as the device-under-test target for the existing APB requester stimulus and for any APB master in the subsystem.

---
 rtl/apb_mem_slave.sv | 112 +++++++++++
 tb/tb_apb_mem_slave.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer backed by a DEPTH-word register file; define APB_SLVERR_EN to add slverr for addr >= DEPTH.
// ready rises in the (WAIT_STATES+1)th enable cycle of ACCESS; enable=0 stalls, sel=0 aborts.
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr,
  input  logic                  sel,
  input  logic                  enable,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef APB_SLVERR_EN
  ,
  output logic                  slverr
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [AW-1:0]         idx, cap_idx;
  logic                  cap_wr;
  logic                  cap_err;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  setup, commit, addr_err;

  assign idx = addr[AW-1:0];

`ifdef APB_SLVERR_EN
  assign addr_err = (addr >= 32'(DEPTH));
  assign slverr   = ready & cap_err;
`else
  // Upper address bits alias onto the low index bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW];
  assign addr_err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    setup     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          setup     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (enable) begin
          if (cnt == 4'(WAIT_STATES)) begin
            ready     = 1'b1;
            commit    = cap_wr & ~cap_err;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Setup and commit happen in different states, so they never collide on one edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_idx  <= '0;
      cap_wr   <= 1'b0;
      cap_err  <= 1'b0;
      cap_data <= '0;
      out_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (setup) begin
        cap_idx  <= idx;
        cap_wr   <= wr;
        cap_err  <= addr_err;
        cap_data <= wr_data;
        out_data <= addr_err ? '0 : mem[idx];
      end
      if (commit) mem[cap_idx] <= cap_data;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: instance 0 with WAIT_STATES=0, instance 1 with WAIT_STATES=2.
module tb_apb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn    [2];
  logic        wr      [2];
  logic        sel     [2];
  logic        enable  [2];
  logic        ready   [2];
  logic [31:0] addr    [2];
  logic [31:0] wr_data [2];
  logic [31:0] out_data[2];
`ifdef APB_SLVERR_EN
  logic        slverr  [2];
  logic        last_err;
`endif

  int pass_cnt = 0;
  int total    = 0;

  apb_mem_slave #(.DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rstn(rstn[0]), .addr(addr[0]), .wr_data(wr_data[0]), .wr(wr[0]),
    .sel(sel[0]), .enable(enable[0]), .ready(ready[0]), .out_data(out_data[0])
`ifdef APB_SLVERR_EN
    , .slverr(slverr[0])
`endif
  );

  apb_mem_slave #(.DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rstn(rstn[1]), .addr(addr[1]), .wr_data(wr_data[1]), .wr(wr[1]),
    .sel(sel[1]), .enable(enable[1]), .ready(ready[1]), .out_data(out_data[1])
`ifdef APB_SLVERR_EN
    , .slverr(slverr[1])
`endif
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          exp_waits;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Setup then enable until ready (bounded); returns at the ready cycle, before the completion edge.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output int waits, output logic [31:0] rd);
    @(negedge clk);
    sel[d] = 1'b1; enable[d] = 1'b0; wr[d] = w; addr[d] = a; wr_data[d] = wd;
    @(negedge clk);
    enable[d] = 1'b1;
    waits = 0;
    #1;
    while (!ready[d] && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rd = out_data[d];
`ifdef APB_SLVERR_EN
    last_err = slverr[d];
`endif
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    sel[d] = 1'b0; enable[d] = 1'b0;
  endtask

  initial begin
    vec_t        tbl[$];
    int          waits;
    logic [31:0] rd;

    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; wr[d] = 1'b0; sel[d] = 1'b0; enable[d] = 1'b0;
      addr[d] = '0; wr_data[d] = '0;
    end

    // Writes 12..16 to 22..26, then reads, then the aliasing/out-of-range case.
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 32'(22 + i), 32'(12 + i), 0, 32'd0, 1'b0});
    tbl.push_back('{1'b0, 32'd23, 32'd0, 0, 32'd13, 1'b0});
    tbl.push_back('{1'b0, 32'd24, 32'd0, 0, 32'd14, 1'b0});
    tbl.push_back('{1'b0, 32'd25, 32'd0, 0, 32'd15, 1'b0});
    tbl.push_back('{1'b0, 32'd22, 32'd0, 0, 32'd12, 1'b0});
    tbl.push_back('{1'b0, 32'd26, 32'd0, 0, 32'd16, 1'b0});
`ifdef APB_SLVERR_EN
    tbl.push_back('{1'b1, 32'd40, 32'h77, 0, 32'd0, 1'b1});
    tbl.push_back('{1'b0, 32'd8,  32'd0,  0, 32'd0, 1'b0});
    tbl.push_back('{1'b0, 32'd40, 32'd0,  0, 32'd0, 1'b1});
`else
    tbl.push_back('{1'b1, 32'd40, 32'h77, 0, 32'd0,  1'b0});
    tbl.push_back('{1'b0, 32'd8,  32'd0,  0, 32'h77, 1'b0});
    tbl.push_back('{1'b0, 32'd40, 32'd0,  0, 32'h77, 1'b0});
`endif

    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ready[%0d]", d), 32'(ready[d]), 32'd0);
      check($sformatf("reset out_data[%0d]", d), out_data[d], 32'd0);
`ifdef APB_SLVERR_EN
      check($sformatf("reset slverr[%0d]", d), 32'(slverr[d]), 32'd0);
`endif
    end
    @(negedge clk);
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    foreach (tbl[i]) begin
      xfer(0, tbl[i].w, tbl[i].a, tbl[i].d, waits, rd);
      idle(0);
      check($sformatf("vec%0d latency", i), 32'(waits), 32'(tbl[i].exp_waits));
      if (!tbl[i].w) check($sformatf("vec%0d out_data", i), rd, tbl[i].exp_rd);
`ifdef APB_SLVERR_EN
      check($sformatf("vec%0d slverr", i), 32'(last_err), 32'(tbl[i].exp_err));
`endif
    end

    // Back-to-back with sel held high: read sees the write committed one edge earlier.
    xfer(0, 1'b1, 32'd7, 32'h11, waits, rd);
    check("b2b write latency", 32'(waits), 32'd0);
    xfer(0, 1'b0, 32'd7, 32'd0, waits, rd);
    idle(0);
    check("b2b read latency", 32'(waits), 32'd0);
    check("b2b read data", rd, 32'h11);

    // Two wait states.
    xfer(1, 1'b1, 32'd5, 32'h55, waits, rd);
    idle(1);
    check("ws2 write latency", 32'(waits), 32'd2);
    xfer(1, 1'b0, 32'd5, 32'd0, waits, rd);
    idle(1);
    check("ws2 read latency", 32'(waits), 32'd2);
    check("ws2 read data", rd, 32'h55);

    // Abort after one enable cycle: no write lands.
    @(negedge clk);
    sel[1] = 1'b1; enable[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'd3; wr_data[1] = 32'hAA;
    @(negedge clk);
    enable[1] = 1'b1;
    #1 check("abort ready low", 32'(ready[1]), 32'd0);
    @(negedge clk);
    sel[1] = 1'b0; enable[1] = 1'b0;
    xfer(1, 1'b0, 32'd3, 32'd0, waits, rd);
    idle(1);
    check("abort read latency", 32'(waits), 32'd2);
    check("abort read data", rd, 32'd0);

    // Asynchronous reset during the ready cycle of a write.
    xfer(1, 1'b1, 32'd1, 32'h33, waits, rd);
    idle(1);
    check("pre-reset write latency", 32'(waits), 32'd2);
    @(negedge clk);
    sel[1] = 1'b1; enable[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'd1; wr_data[1] = 32'h99;
    @(negedge clk);
    enable[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("mid-reset ready before", 32'(ready[1]), 32'd1);
    check("mid-reset out_data before", out_data[1], 32'h33);
    rstn[1] = 1'b0;
    #1;
    check("mid-reset ready during", 32'(ready[1]), 32'd0);
    check("mid-reset out_data during", out_data[1], 32'd0);
    #2;
    sel[1] = 1'b0; enable[1] = 1'b0; rstn[1] = 1'b1;
    xfer(1, 1'b0, 32'd1, 32'd0, waits, rd);
    idle(1);
    check("post-reset read latency", 32'(waits), 32'd2);
    check("post-reset read data", rd, 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
